// File: rtl/scan_decoder_if.sv
// Control/status bundle for scan_decoder: the master drives the controls, the
// slave (the decoder) returns the one-hot lines, the index and the wrap pulse.
interface scan_decoder_if #(
  parameter int unsigned SEL_W = 2,
  parameter int unsigned DIV_W = 8
);
  localparam int unsigned N_OUT = 1 << SEL_W;

  logic             en;
  logic             mode;
  logic             load;
  logic [SEL_W-1:0] sel;
  logic [DIV_W-1:0] div;
  logic [N_OUT-1:0] out;
  logic [SEL_W-1:0] idx;
  logic             wrap;

  modport master (output en, mode, load, sel, div, input out, idx, wrap);
  modport slave  (input en, mode, load, sel, div, output out, idx, wrap);
endinterface

// File: rtl/scan_decoder.sv
// One-hot decoder with a direct-load mode and a prescaled auto-scan mode.
// Define SCAN_DECODER_BLANK_EN to blank the outputs on the last cycle of each scan period.
module scan_decoder #(
  parameter int unsigned SEL_W = 2,
  parameter int unsigned DIV_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  scan_decoder_if.slave bus
);
  localparam int unsigned    N_OUT   = 1 << SEL_W;
  localparam logic [SEL_W-1:0] IDX_MAX = SEL_W'(N_OUT - 1);

  typedef enum logic [1:0] {ST_OFF, ST_DIRECT, ST_SCAN} state_e;

  state_e           state_c;
  logic [SEL_W-1:0] idx_q,  idx_d;
  logic [DIV_W-1:0] cnt_q,  cnt_d;
  logic [N_OUT-1:0] out_q,  out_d;
  logic             wrap_q, wrap_d;
  logic             blank_c;

  // Operating state is a direct decode of en/mode so a change takes effect on the next edge.
  always_comb begin
    state_c = ST_OFF;
    if (bus.en) state_c = bus.mode ? ST_SCAN : ST_DIRECT;
  end

  always_comb begin
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    blank_c = 1'b0;
    out_d   = '0;
    case (state_c)
      ST_DIRECT: begin
        cnt_d = '0;
        if (bus.load) idx_d = bus.sel;
      end
      ST_SCAN: begin
        // A load wins over a coincident step and restarts the period.
        if (bus.load) begin
          idx_d = bus.sel;
          cnt_d = '0;
        end else if (cnt_q == bus.div) begin
          cnt_d  = '0;
          idx_d  = idx_q + SEL_W'(1);
          wrap_d = (idx_q == IDX_MAX);
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: ;
    endcase
`ifdef SCAN_DECODER_BLANK_EN
    blank_c = (state_c == ST_SCAN) && (bus.div != '0) && (cnt_d == bus.div);
`else
    blank_c = 1'b0;
`endif
    if ((state_c != ST_OFF) && !blank_c) out_d = N_OUT'(1) << idx_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;
endmodule
